register_file_2r1w: RTL and testbench
=====================================

# register_file_2r1w

Two-read, one-write 32 x 32-bit register file with a hardwired-zero register 0 and synchronous active-high reset. It is the responder side of the register-file interface driven by the team's register-file test bench and, later, by the CPU decode/writeback stages. Reads are combinational. Writes commit on the rising clock edge.

## Interface
Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, address width; register count is 2^ADDR_W = 32

Ports:
- Clk  input  1  clock, positive-edge triggered
- Reset  input  1  synchronous, active-high; clears every register on the rising edge of Clk
- ReadRegister1  input  ADDR_W  address for read port 1
- ReadRegister2  input  ADDR_W  address for read port 2
- ReadData1  output  DATA_W  contents of ReadRegister1 (combinational)
- ReadData2  output  DATA_W  contents of ReadRegister2 (combinational)
- WriteRegister  input  ADDR_W  address for the write port
- WriteData  input  DATA_W  data for the write port
- RegWrite  input  1  write enable, active-high

One clock domain: Clk. Reset is synchronous and active-high.

## Operation
- **Storage:**
  - Registers 1..31 are 32-bit flops, each with an enable and a synchronous clear.
  - Register 0 has no storage and always reads 0.
- **Write decode:**
  - Per-register enable = RegWrite AND (WriteRegister == i) AND (i != 0).
  - Exactly one register, or none, is enabled per cycle.
- **Write commit:**
  - On posedge Clk with the enable for register i high and Reset low, reg[i] <= WriteData.
  - All other registers hold their value.
- **Reset:**
  - On posedge Clk with Reset high, all registers <= 0.
  - Reset has priority over any write in the same cycle; the write is dropped.
- **Read ports:**
  - Each port is an independent 32:1 mux of register contents.
  - Both ports may address the same register, or different ones, in the same cycle.
- **No write-to-read bypass:**
  - Reading the register being written returns the old value until the clock edge.
  - It returns the new value after the edge.
- **Widths:**
  - All addresses are full ADDR_W; there are no out-of-range addresses.
  - Data is stored verbatim; there is no sign or width conversion.

## Timing
- **Write latency:** data driven with RegWrite=1 is visible on ReadData1/2 immediately after the next rising edge of Clk, after combinational settle. There is no extra pipeline stage.
- **Read latency:** zero cycles. ReadDataN follows ReadRegisterN and register state combinationally.
- **Reset values:**
  - After one Clk edge with Reset=1, every register is 0, so ReadData1 = ReadData2 = 0 for every address.
  - Contents before the first reset edge are undefined; benches must reset first.
- **Reset mid-operation:**
  - Reset asserted while RegWrite=1 clears everything and drops the write.
  - A write on the first cycle after Reset deasserts commits normally.
- **Register 0 writes:** RegWrite=1 with WriteRegister=0 is a legal no-op. No register changes, and reads of address 0 stay 0.
- **Disabled writes:** RegWrite=0 changes nothing, regardless of WriteRegister or WriteData.
- **Back-to-back writes:** consecutive cycles may write the same or different registers; each edge commits independently.

## Structure
Shared package/include holds:
- DATA_W = 32
- ADDR_W = 5
- NUM_REGS = 32
- ZERO_REG = 5'd0

Sub-module `register32` is natural: DATA_W-bit flop with inputs d, wrenable, Reset, Clk and output q, instantiated 31 times.

Top level contains:
- the 5-to-32 one-hot write decoder, gated by RegWrite
- register 0 tied to 0
- the two 32:1 read muxes, as generate/array logic

## Test plan
- **Reset clears all:** write 32'hFFFF_FFFF to registers 1..31, pulse Reset one cycle, then sweep both read ports over 0..31 -> every read = 0.
- **Basic write/read:** write 42 to r2, then 15 to r2 -> ReadData1 = ReadData2 = 42 after the first edge and 15 after the second.
- **Enable and zero register:** write 18 to r2 with RegWrite=0 -> r2 still 15; write 3 to r0 with RegWrite=1 -> r0 reads 0.
- **Decoder isolation:** write 7 to r3 after filling rN = N -> r3 reads 7, every other register reads its own index N.
- **Independent ports and sweep:** write rN = N for N = 1..31, then read port 1 ascending and port 2 descending -> ReadData1 = i and ReadData2 = 31 - i each cycle, with 0 where the address is 0.
- **Reset versus write:** assert Reset and RegWrite (r5 <- 99) in the same cycle -> r5 = 0; the next cycle writes r5 <- 99 -> r5 = 99.

Source files
------------

// File: rtl/register_file_2r1w_pkg.sv
// Shared sizing constants for the 2-read / 1-write register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
package register_file_2r1w_pkg;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_2r1w_register32.sv
// One storage word of the register file: enabled flop with synchronous clear.
// Latency: d appears on q one Clk edge after wrenable is sampled high.
// Backpressure: none; Reset overrides wrenable on the same edge.
module register32
    import register_file_2r1w_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         wrenable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear has priority so a write coinciding with reset is dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= '0;
        end else if (wrenable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// 32 x 32-bit register file, two combinational read ports, one write port, r0 hardwired to zero.
// Latency: reads 0 cycles; writes visible right after the committing Clk edge (no bypass).
// Backpressure: none; every write is accepted, writes to r0 are silently discarded.
module register_file_2r1w
    import register_file_2r1w_pkg::*;
#(
    parameter int DATA_W = register_file_2r1w_pkg::DATA_W,
    parameter int ADDR_W = register_file_2r1w_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite
);

    localparam int NREGS = 1 << ADDR_W;

    // Register contents as seen by the read muxes; entry 0 is a constant.
    logic [DATA_W-1:0] regs [NREGS];

    // One-hot write enables; r0 has no storage so it gets no enable.
    logic [NREGS-1:1]  wr_en;

    assign regs[ZERO_REG] = '0;

    // Decoder and storage: one enable per real register, gated by RegWrite.
    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        assign wr_en[i] = RegWrite && (WriteRegister == ADDR_W'(i));

        register32 #(
            .W (DATA_W)
        ) u_reg (
            .Clk      (Clk),
            .Reset    (Reset),
            .wrenable (wr_en[i]),
            .d        (WriteData),
            .q        (regs[i])
        );
    end

    // Independent 32:1 read muxes; state is read directly, so a write in
    // flight is not forwarded until its edge has committed.
    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: vector table, directed corner sequences, random traffic.
// Latency: checks reads combinationally and one edge after each write.
// Backpressure: n/a.
module tb_register_file_2r1w;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;

    int tests  = 0;
    int errors = 0;

    // Behavioural view of the architectural register state.
    logic [31:0] mdl [32];

    register_file_2r1w #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one write-port cycle, let the edge commit it, update the model.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        Reset         = rst;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        @(posedge Clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
        end else if (we && wa != 5'd0) begin
            mdl[wa] = wd;
        end
        #1;
        Reset    = 1'b0;
        RegWrite = 1'b0;
    endtask

    initial begin
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] wd;

        Reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        for (int k = 0; k < 32; k++) mdl[k] = 32'd0;

        // Cycle-by-cycle vectors: inputs applied for one edge, reads checked just after it.
        vecs[0] = '{"reset_state",   1'b1, 1'b0, 5'd0,  32'd0,          5'd0,  5'd31, 32'd0,          32'd0};
        vecs[1] = '{"write42_r2",    1'b0, 1'b1, 5'd2,  32'd42,         5'd2,  5'd2,  32'd42,         32'd42};
        vecs[2] = '{"write15_r2",    1'b0, 1'b1, 5'd2,  32'd15,         5'd2,  5'd2,  32'd15,         32'd15};
        vecs[3] = '{"disabled_wr",   1'b0, 1'b0, 5'd2,  32'd18,         5'd2,  5'd0,  32'd15,         32'd0};
        vecs[4] = '{"r0_write",      1'b0, 1'b1, 5'd0,  32'd3,          5'd0,  5'd2,  32'd0,          32'd15};
        vecs[5] = '{"rst_vs_write",  1'b1, 1'b1, 5'd5,  32'd99,         5'd5,  5'd2,  32'd0,          32'd0};
        vecs[6] = '{"wr_after_rst",  1'b0, 1'b1, 5'd5,  32'd99,         5'd5,  5'd0,  32'd99,         32'd0};
        vecs[7] = '{"write_r31",     1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF,  5'd31, 5'd5,  32'hFFFF_FFFF,  32'd99};
        vecs[8] = '{"b2b_r30",       1'b0, 1'b1, 5'd30, 32'h8000_0001,  5'd30, 5'd31, 32'h8000_0001,  32'hFFFF_FFFF};

        for (int v = 0; v < 9; v++) begin
            ReadRegister1 = vecs[v].ra1;
            ReadRegister2 = vecs[v].ra2;
            cyc(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd);
            #1;
            chk({vecs[v].name, "_p1"}, ReadData1, vecs[v].exp1);
            chk({vecs[v].name, "_p2"}, ReadData2, vecs[v].exp2);
        end

        // Reset clears all: fill with ones, one reset pulse, sweep both ports.
        for (int n = 1; n < 32; n++) cyc(1'b0, 1'b1, 5'(n), 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 5'd0, 32'd0);
        for (int n = 0; n < 32; n++) begin
            ReadRegister1 = 5'(n);
            ReadRegister2 = 5'(31 - n);
            #1;
            chk("reset_clear_p1", ReadData1, 32'd0);
            chk("reset_clear_p2", ReadData2, 32'd0);
        end

        // Fill rN = N, then sweep port 1 ascending and port 2 descending.
        for (int n = 1; n < 32; n++) cyc(1'b0, 1'b1, 5'(n), 32'(n));
        for (int n = 0; n < 32; n++) begin
            ReadRegister1 = 5'(n);
            ReadRegister2 = 5'(31 - n);
            @(posedge Clk);
            #1;
            chk("sweep_p1", ReadData1, 32'(n));
            chk("sweep_p2", ReadData2, 32'(31 - n));
        end

        // Decoder isolation: only r3 changes.
        cyc(1'b0, 1'b1, 5'd3, 32'd7);
        for (int n = 0; n < 32; n++) begin
            ReadRegister1 = 5'(n);
            #1;
            chk("decode_iso", ReadData1, (n == 3) ? 32'd7 : 32'(n));
        end

        // No bypass: old value before the edge, new value after it.
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
        WriteRegister = 5'd9; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
        #1;
        chk("no_bypass_before", ReadData1, 32'd9);
        @(posedge Clk);
        mdl[9] = 32'hDEAD_BEEF;
        #1;
        RegWrite = 1'b0;
        chk("no_bypass_after_p1", ReadData1, 32'hDEAD_BEEF);
        chk("no_bypass_after_p2", ReadData2, 32'hDEAD_BEEF);

        // Random traffic against the model, checking reads both before and after each edge.
        for (int it = 0; it < 400; it++) begin
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            ReadRegister1 = a1;
            ReadRegister2 = a2;
            #1;
            chk("rand_pre_p1", ReadData1, mdl[a1]);
            chk("rand_pre_p2", ReadData2, mdl[a2]);
            wd = $urandom;
            cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                (($urandom_range(0, 7) == 0) ? a1 : 5'($urandom_range(0, 31))), wd);
            #1;
            chk("rand_post_p1", ReadData1, mdl[a1]);
            chk("rand_post_p2", ReadData2, mdl[a2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
